// File: rtl/obi_host_pipelined_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : obi_host_pipelined_driver_pkg
// Brief    : Shared widths, transaction-kind tag and byte-enable helper.
// Revision : 1.0
// ============================================================================
package obi_host_pipelined_driver_pkg;

  localparam int unsigned OBI_DEF_ADDR_W          = 64;
  localparam int unsigned OBI_DEF_DATA_W          = 64;
  localparam int unsigned OBI_DEF_MAX_OUTSTANDING = 2;

  typedef enum logic {
    TXN_READ  = 1'b0,
    TXN_WRITE = 1'b1
  } txn_kind_e;

  function automatic int unsigned obi_be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_host_pipelined_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : obi_host_pipelined_driver_if
// Brief    : Host-side request/response and OBI bus signals of the driver.
// Revision : 1.0
// ============================================================================
interface obi_host_pipelined_driver_if
  import obi_host_pipelined_driver_pkg::*;
#(
  parameter int unsigned ADDR_W = OBI_DEF_ADDR_W,
  parameter int unsigned DATA_W = OBI_DEF_DATA_W
);
  localparam int unsigned BE_W = obi_be_w(DATA_W);

  logic              rd_i;
  logic              wr_i;
  logic [BE_W-1:0]   be_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              stall_o;
  logic              req_o;
  logic              gnt_i;
  logic              we_o;
  logic [BE_W-1:0]   be_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] wdata_o;
  logic              rvalid_i;
  logic [DATA_W-1:0] rdata_i;
  logic              rvalid_o;
  logic              rwe_o;
  logic [DATA_W-1:0] rdata_o;
  logic              idle_o;
  logic              err_o;

  // The driver is the OBI master; the environment (core + bus) is the slave side.
  modport master (
    input  rd_i, wr_i, be_i, addr_i, wdata_i, gnt_i, rvalid_i, rdata_i,
    output stall_o, req_o, we_o, be_o, addr_o, wdata_o,
           rvalid_o, rwe_o, rdata_o, idle_o, err_o
  );

  modport slave (
    output rd_i, wr_i, be_i, addr_i, wdata_i, gnt_i, rvalid_i, rdata_i,
    input  stall_o, req_o, we_o, be_o, addr_o, wdata_o,
           rvalid_o, rwe_o, rdata_o, idle_o, err_o
  );

endinterface
`default_nettype wire

// File: rtl/obi_host_pipelined_driver_txn_fifo.sv
`default_nettype none
// ============================================================================
// Module   : obi_host_pipelined_driver_txn_fifo
// Brief    : In-order tag FIFO of outstanding transaction kinds, any depth >= 1.
// Revision : 1.0
// ============================================================================
module obi_host_pipelined_driver_txn_fifo
  import obi_host_pipelined_driver_pkg::*;
#(
  parameter int unsigned DEPTH = OBI_DEF_MAX_OUTSTANDING
) (
  input  wire logic  clk_i,
  input  wire logic  rst_i,
  input  wire logic  i_push,
  input  txn_kind_e  i_push_kind,
  input  wire logic  i_pop,
  output txn_kind_e  o_head,
  output logic       o_empty,
  output logic       o_full
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

  txn_kind_e         r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == C_LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == C_DEPTH);
  assign o_head    = r_mem[r_rd_ptr];
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_kind;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/obi_host_pipelined_driver.sv
`default_nettype none
// ============================================================================
// Module   : obi_host_pipelined_driver
// Brief    : OBI host driver with up to MAX_OUTSTANDING in-order transactions.
// Revision : 1.0
// ============================================================================
module obi_host_pipelined_driver
  import obi_host_pipelined_driver_pkg::*;
#(
  parameter int unsigned ADDR_W          = OBI_DEF_ADDR_W,
  parameter int unsigned DATA_W          = OBI_DEF_DATA_W,
  parameter int unsigned MAX_OUTSTANDING = OBI_DEF_MAX_OUTSTANDING
) (
  input wire logic                       clk_i,
  input wire logic                       rst_i,
  obi_host_pipelined_driver_if.master    bus
);
  localparam int unsigned BE_W = obi_be_w(DATA_W);

  logic              r_hold;
  logic              r_err;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_host_req;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_slot_ok;
  logic              w_req;
  logic              w_accept;
  logic              w_pop;
  txn_kind_e         w_push_kind;
  txn_kind_e         w_head;

  assign w_host_req = bus.rd_i | bus.wr_i;
  // A response retiring this cycle frees its slot for a request in the same cycle.
  assign w_slot_ok  = ~w_fifo_full | (bus.rvalid_i & ~w_fifo_empty);
  assign w_req      = r_hold | (w_host_req & w_slot_ok);
  assign w_accept   = w_req & bus.gnt_i;
  assign w_pop      = bus.rvalid_i & ~w_fifo_empty;

  assign bus.req_o   = w_req;
  assign bus.we_o    = r_hold ? r_we    : bus.wr_i;
  assign bus.be_o    = r_hold ? r_be    : bus.be_i;
  assign bus.addr_o  = r_hold ? r_addr  : bus.addr_i;
  assign bus.wdata_o = r_hold ? r_wdata : bus.wdata_i;
  assign bus.stall_o = r_hold | (w_host_req & ~w_slot_ok) | (w_req & ~bus.gnt_i);

  assign w_push_kind  = bus.we_o ? TXN_WRITE : TXN_READ;
  assign bus.rvalid_o = w_pop;
  assign bus.rwe_o    = (w_head == TXN_WRITE);
  assign bus.rdata_o  = bus.rdata_i;
  assign bus.idle_o   = w_fifo_empty & ~r_hold;
  assign bus.err_o    = r_err;

  // Attributes are captured only on the first ungranted cycle so the bus sees them frozen.
  always_ff @(posedge clk_i) begin
    if (w_req & ~bus.gnt_i & ~r_hold) begin
      r_we    <= bus.wr_i;
      r_be    <= bus.be_i;
      r_addr  <= bus.addr_i;
      r_wdata <= bus.wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_hold <= w_req & ~bus.gnt_i;
      if ((bus.rvalid_i & w_fifo_empty) | (bus.rd_i & bus.wr_i)) begin
        r_err <= 1'b1;
      end
    end
  end

  obi_host_pipelined_driver_txn_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_txn_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_push      (w_accept),
    .i_push_kind (w_push_kind),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

endmodule
`default_nettype wire
